// File: rtl/div_serial_pkg.sv
// Shared constants for the serial divider: FSM state encodings,
// default operand width and the busy/free handshake levels.
package div_serial_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic DIV_FREE = 1'b0;
    localparam logic DIV_BUSY = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_serial_if.sv
// Operand/result handshake between the ALU (master) and the divider (slave).
interface div_serial_if
    import div_serial_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               cancel;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sign;
    logic               opn_valid;
    logic               res_ready;
    logic               res_valid;
    logic               busy;
    logic [2*WIDTH-1:0] result;

    modport master (
        output cancel, a, b, sign, opn_valid, res_ready,
        input  res_valid, busy, result
    );

    modport slave (
        input  cancel, a, b, sign, opn_valid, res_ready,
        output res_valid, busy, result
    );

endinterface

// File: rtl/div_serial_sign_fix.sv
// Conditional two's-complement negate. Used as abs() on the operands
// (neg = operand is negative) and as the sign restore on quotient/remainder.
module div_serial_sign_fix
    import div_serial_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Negate when requested, pass through otherwise.
    always_comb begin
        res = neg ? -val : val;
    end

endmodule

// File: rtl/div_serial.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces result = {remainder, quotient}, one quotient bit per CALC cycle.
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately when
// the dividend magnitude is below a nonzero divisor magnitude.
//
//   state | meaning
//   IDLE  | waiting for opn_valid; operands latched on accept
//   CALC  | shift/subtract, WIDTH cycles, MSB first
//   DONE  | result held with res_valid until res_ready
module div_serial
    import div_serial_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    div_serial_if.slave    bus
);

    div_state_t       state;
    div_state_t       state_nx;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    // The partial remainder after a restore is always below the divisor, so
    // only the shifted trial value needs the extra bit.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] dvd_nx;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    logic             accept;
    logic             last;
    logic             early;

    div_serial_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val (bus.a),
        .neg (bus.sign & bus.a[WIDTH-1]),
        .res (a_abs)
    );

    div_serial_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val (bus.b),
        .neg (bus.sign & bus.b[WIDTH-1]),
        .res (b_abs)
    );

    div_serial_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .val (dvd_nx),
        .neg (sign_q),
        .res (q_fix)
    );

    div_serial_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .val (rem_nx),
        .neg (sign_r),
        .res (r_fix)
    );

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // A set top bit in the shifted value always means it exceeds the divisor;
    // otherwise the borrow of the trial subtraction decides. With a zero
    // divisor every step subtracts nothing, giving all-ones quotient and
    // the dividend as remainder.
    always_comb begin
        rem_sh  = {rem, dvd[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        ge      = rem_sh[WIDTH] | ~rem_sub[WIDTH];
        rem_nx  = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_nx  = {dvd[WIDTH-2:0], ge};
    end

    // Accept, last-iteration and early-out qualifiers.
    always_comb begin
        accept = (state == DIV_IDLE) & bus.opn_valid & ~bus.cancel;
        last   = (cnt == CNT_W'(WIDTH - 1));
`ifdef DIV_EARLY_OUT_EN
        early  = (b_abs != '0) && (a_abs < b_abs);
`else
        early  = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; cancel overrides every other transition.
    always_comb begin
        state_nx = state;
        if (bus.cancel) begin
            state_nx = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (bus.opn_valid) state_nx = early ? DIV_DONE : DIV_CALC;
                DIV_CALC: if (last)          state_nx = DIV_DONE;
                DIV_DONE: if (bus.res_ready) state_nx = DIV_IDLE;
                default:                     state_nx = DIV_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.res_valid = (state == DIV_DONE);
        bus.busy      = (state != DIV_IDLE) ? DIV_BUSY : DIV_FREE;
    end

    // Datapath: latch magnitudes on accept, iterate in CALC, write the
    // sign-corrected result on the final iteration. Cancel freezes everything,
    // including the previous result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            bus.result <= '0;
        end else if (!bus.cancel) begin
            if (accept) begin
                dvd    <= a_abs;
                dvs    <= b_abs;
                rem    <= '0;
                cnt    <= '0;
                sign_q <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                sign_r <= bus.sign & bus.a[WIDTH-1];
                if (early) begin
                    bus.result <= {bus.a, {WIDTH{1'b0}}};
                end
            end else if (state == DIV_CALC) begin
                rem <= rem_nx;
                dvd <= dvd_nx;
                cnt <= cnt + CNT_W'(1);
                if (last) begin
                    bus.result <= {r_fix, q_fix};
                end
            end
        end
    end

endmodule

// File: tb/tb_div_serial.sv
// Self-checking bench for div_serial: directed corners plus random operands
// against an arithmetic reference model.
module tb_div_serial;
    import div_serial_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] last_res = '0;

    div_serial_if #(.WIDTH(W)) bus ();

    div_serial #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned division, with the no-trap rules for b==0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            r = a;
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Edge (counting the accept edge as 0) at which res_valid is first seen.
    function automatic int exp_edge(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint ma;
        longint mb;
        bit     early_en;
`ifdef DIV_EARLY_OUT_EN
        early_en = 1'b1;
`else
        early_en = 1'b0;
`endif
        ma = s ? ((a[31]) ? -longint'($signed(a)) : longint'(a)) : longint'(a);
        mb = s ? ((b[31]) ? -longint'($signed(b)) : longint'(b)) : longint'(b);
        if (early_en && b != 32'd0 && ma < mb) return 1;
        return W + 1;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int stall, input bit keep_valid, input string tag);
        logic [63:0] exp;
        int lat;
        int eedge;
        exp   = model(a, b, s);
        eedge = exp_edge(a, b, s);
        bus.a = a;
        bus.b = b;
        bus.sign = s;
        bus.opn_valid = 1'b1;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        if (!keep_valid) begin
            bus.opn_valid = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.sign = 1'($urandom_range(1, 0));
        end
        check({tag, ":busy"}, 64'(bus.busy), 64'd1);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 3 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat + 1), 64'(eedge));
        check({tag, ":result"}, bus.result, exp);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) begin
            check({tag, ":hold_valid"}, 64'(bus.res_valid), 64'd1);
            check({tag, ":hold_result"}, bus.result, exp);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        bus.opn_valid = 1'b0;
        check({tag, ":idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, ":idle_valid"}, 64'(bus.res_valid), 64'd0);
        last_res = exp;
    endtask

    task automatic run_cancel();
        bit seen;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        bus.sign = 1'b0;
        bus.opn_valid = 1'b1;
        @(posedge clk); #1;
        bus.opn_valid = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen = 1'b1;
        end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel:busy", 64'(bus.busy), 64'd0);
        check("cancel:result_kept", bus.result, last_res);
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen = 1'b1;
        end
        check("cancel:never_valid", 64'(seen), 64'd0);
    endtask

    task automatic run_reset();
        bus.a = 32'd1000;
        bus.b = 32'd7;
        bus.sign = 1'b0;
        bus.opn_valid = 1'b1;
        @(posedge clk); #1;
        bus.opn_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst:valid", 64'(bus.res_valid), 64'd0);
        check("rst:busy", 64'(bus.busy), 64'd0);
        check("rst:result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        last_res = '0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.cancel = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sign = 1'b0;
        bus.opn_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:valid", 64'(bus.res_valid), 64'd0);
        check("reset:busy", 64'(bus.busy), 64'd0);
        check("reset:result", bus.result, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_idle:busy", 64'(bus.busy), 64'd0);

        run_op(32'd100, 32'd7, 1'b0, 0, 1'b1, "divu_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b1, "div_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "div_min_m1");
        run_op(32'd5, 32'd0, 1'b0, 0, 1'b0, "divu_5_0");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 0, 1'b1, "div_m5_0");
        run_op(32'd5, 32'd0, 1'b1, 0, 1'b0, "div_5_0");
        run_op(32'd123456, 32'd789, 1'b0, 10, 1'b1, "backpressure");
        run_op(32'd9, 32'd3, 1'b0, 0, 1'b0, "back_to_back");
        run_cancel();
        run_op(32'd50, 32'd6, 1'b0, 0, 1'b0, "after_cancel");
        run_reset();
        run_op(32'hFFFF_FF00, 32'd17, 1'b1, 1, 1'b0, "after_reset");
        run_op(32'd3, 32'd10, 1'b0, 0, 1'b0, "divu_3_10");
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 2, 1'b1, "div_m3_10");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(3, 0))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(15, 1));
                2: begin rb = $urandom; ra = 32'($urandom_range(255, 0)); end
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom_range(1, 0)), $urandom_range(3, 0),
                   1'($urandom_range(1, 0)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
